// File: rtl/pblaze_uart_pkg.sv
// Shared definitions for the PicoBlaze UART port: register offsets relative
// to BASE_PORT, STATUS bit positions, TX/RX state encodings and the baud
// divisor helper.
package pblaze_uart_pkg;

    // Register offsets relative to BASE_PORT
    localparam logic [2:0] OFS_STATUS = 3'd0;
    localparam logic [2:0] OFS_DATA   = 3'd1;
    localparam logic [2:0] OFS_DIV_LO = 3'd2;
    localparam logic [2:0] OFS_DIV_HI = 3'd3;
    localparam logic [2:0] OFS_IRQ_EN = 3'd4;
    localparam int         NUM_REGS   = 5;

    // STATUS bit positions
    localparam int ST_TX_HALF    = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_HALF    = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_PRESENT = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_OVERRUN    = 6;
    localparam int ST_IRQ_PEND   = 7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A divisor of zero behaves like one: en_16x every cycle.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/pblaze_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// Ports: clk, rst_n (async active-low), push/wdata write side, pop/rdata
// read side, empty/full/half status (half = count >= DEPTH/2).
// A push while full is dropped unless a pop happens in the same cycle;
// a pop while empty is ignored.
module pblaze_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             half
);
    import pblaze_uart_pkg::*;

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_HALF = (AW + 1)'(DEPTH / 2);
    localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign full      = (count_r == CNT_FULL);
    assign half      = (count_r >= CNT_HALF);
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_push_s = push && (!full || do_pop_s);

    // Storage array; no reset needed, contents are qualified by count_r.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pblaze_uart_port.sv
// PicoBlaze I/O-port UART: 8N1 transmitter and receiver with TX/RX FIFOs,
// programmable 16x baud divisor and a level interrupt.
// Ports: clk, rst_n (async active-low); processor side port_id, out_port,
// write_strobe, read_strobe, in_port (registered read data), interrupt;
// serial side rx (async input, idle high), tx (idle high).
// Register map at BASE_PORT+0..4: STATUS / error clear, RXDATA / TXDATA,
// DIV_LO, DIV_HI, IRQ_EN.
module pblaze_uart_port #(
    parameter logic [7:0]  BASE_PORT  = 8'h00,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       rx,
    output logic       tx
);
    import pblaze_uart_pkg::*;

    // Address decode
    logic [7:0] ofs_s;
    logic       in_range_s;
    logic       sel_status_s, sel_data_s, sel_div_lo_s, sel_div_hi_s, sel_irq_en_s;

    assign ofs_s        = port_id - BASE_PORT;
    assign in_range_s   = (ofs_s < 8'(NUM_REGS));
    assign sel_status_s = in_range_s && (ofs_s[2:0] == OFS_STATUS);
    assign sel_data_s   = in_range_s && (ofs_s[2:0] == OFS_DATA);
    assign sel_div_lo_s = in_range_s && (ofs_s[2:0] == OFS_DIV_LO);
    assign sel_div_hi_s = in_range_s && (ofs_s[2:0] == OFS_DIV_HI);
    assign sel_irq_en_s = in_range_s && (ofs_s[2:0] == OFS_IRQ_EN);

    logic wr_status_s, wr_div_lo_s, wr_div_hi_s, wr_irq_en_s, tx_push_s;
    assign wr_status_s = write_strobe && sel_status_s;
    assign wr_div_lo_s = write_strobe && sel_div_lo_s;
    assign wr_div_hi_s = write_strobe && sel_div_hi_s;
    assign wr_irq_en_s = write_strobe && sel_irq_en_s;
    assign tx_push_s   = write_strobe && sel_data_s;

    // Control registers and state
    logic [15:0] div_r;
    logic [2:0]  irq_en_r;
    logic [15:0] baud_cnt_r;
    logic        en_16x_s;
    logic        rx_rd_r;
    logic        overrun_r, frame_err_r;

    tx_state_t   tx_state_r;
    logic [3:0]  tx_tick_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        tx_pop_s;

    rx_state_t   rx_state_r;
    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    logic [3:0]  rx_tick_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_push_r, set_frame_r, set_ovr_r;

    logic [7:0]  tx_head_s, rx_head_s;
    logic        tx_empty_s, tx_full_s, tx_half_s;
    logic        rx_empty_s, rx_full_s, rx_half_s;
    logic [7:0]  status_s;
    logic [7:0]  rd_data_s;
    logic [2:0]  irq_src_s;

    pblaze_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push_s),
        .wdata (out_port),
        .pop   (tx_pop_s),
        .rdata (tx_head_s),
        .empty (tx_empty_s),
        .full  (tx_full_s),
        .half  (tx_half_s)
    );

    pblaze_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push_r),
        .wdata (rx_shift_r),
        .pop   (rx_rd_r),
        .rdata (rx_head_s),
        .empty (rx_empty_s),
        .full  (rx_full_s),
        .half  (rx_half_s)
    );

    // Divisor, interrupt enable and delayed RX-read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= DIV_RESET;
            irq_en_r <= 3'd0;
            rx_rd_r  <= 1'b0;
        end else begin
            if (wr_div_lo_s) begin
                div_r[7:0] <= out_port;
            end
            if (wr_div_hi_s) begin
                div_r[15:8] <= out_port;
            end
            if (wr_irq_en_s) begin
                irq_en_r <= out_port[2:0];
            end
            // The RX head is popped one cycle after the read so that the
            // registered in_port has already captured it.
            rx_rd_r <= read_strobe && sel_data_s;
        end
    end

    assign en_16x_s = (baud_cnt_r == (eff_div(div_r) - 16'd1));

    // Baud counter: 0..DIV-1, restarted by any divisor write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_r <= 16'd0;
        end else if (wr_div_lo_s || wr_div_hi_s || en_16x_s) begin
            baud_cnt_r <= 16'd0;
        end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
        end
    end

    // A byte leaves the FIFO when a frame starts from idle or chains off a stop bit.
    assign tx_pop_s = en_16x_s && !tx_empty_s &&
                      ((tx_state_r == TX_IDLE) ||
                       ((tx_state_r == TX_STOP) && (tx_tick_r == 4'd15)));

    // Transmit FSM: 16 ticks per bit, LSB first, registered tx line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx         <= 1'b1;
        end else if (en_16x_s) begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (!tx_empty_s) begin
                        tx_shift_r <= tx_head_s;
                        tx_tick_r  <= 4'd0;
                        tx         <= 1'b0;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    tx_tick_r <= tx_tick_r + 4'd1;
                    if (tx_tick_r == 4'd15) begin
                        tx         <= tx_shift_r[0];
                        tx_bit_r   <= 3'd0;
                        tx_state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    tx_tick_r <= tx_tick_r + 4'd1;
                    if (tx_tick_r == 4'd15) begin
                        if (tx_bit_r == 3'd7) begin
                            tx         <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx         <= tx_shift_r[1];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_bit_r   <= tx_bit_r + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    tx_tick_r <= tx_tick_r + 4'd1;
                    if (tx_tick_r == 4'd15) begin
                        if (!tx_empty_s) begin
                            tx_shift_r <= tx_head_s;
                            tx         <= 1'b0;
                            tx_state_r <= TX_START;
                        end else begin
                            tx_state_r <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    tx         <= 1'b1;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM: mid-start check at tick 8, then sample every 16 ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r  <= RX_IDLE;
            rx_tick_r   <= 4'd0;
            rx_bit_r    <= 3'd0;
            rx_shift_r  <= 8'd0;
            rx_push_r   <= 1'b0;
            set_frame_r <= 1'b0;
            set_ovr_r   <= 1'b0;
        end else begin
            rx_push_r   <= 1'b0;
            set_frame_r <= 1'b0;
            set_ovr_r   <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_tick_r  <= 4'd0;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (en_16x_s) begin
                        rx_tick_r <= rx_tick_r + 4'd1;
                        if (rx_tick_r == 4'd7) begin
                            if (rx_sync_r) begin
                                rx_state_r <= RX_IDLE;  // too short: glitch
                            end else begin
                                rx_tick_r  <= 4'd0;
                                rx_bit_r   <= 3'd0;
                                rx_state_r <= RX_DATA;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (en_16x_s) begin
                        rx_tick_r <= rx_tick_r + 4'd1;
                        if (rx_tick_r == 4'd15) begin
                            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                            rx_bit_r   <= rx_bit_r + 3'd1;
                            if (rx_bit_r == 3'd7) begin
                                rx_state_r <= RX_STOP;
                            end
                        end
                    end
                end
                RX_STOP: begin
                    if (en_16x_s) begin
                        rx_tick_r <= rx_tick_r + 4'd1;
                        if (rx_tick_r == 4'd15) begin
                            rx_state_r <= RX_IDLE;
                            if (!rx_sync_r) begin
                                set_frame_r <= 1'b1;
                            end else if (rx_full_s) begin
                                set_ovr_r <= 1'b1;
                            end else begin
                                rx_push_r <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (set_ovr_r) begin
                overrun_r <= 1'b1;
            end else if (wr_status_s && out_port[6]) begin
                overrun_r <= 1'b0;
            end
            if (set_frame_r) begin
                frame_err_r <= 1'b1;
            end else if (wr_status_s && out_port[5]) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    assign irq_src_s = {frame_err_r | overrun_r,
                        tx_empty_s && (tx_state_r == TX_IDLE),
                        !rx_empty_s};

    // Registered level interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interrupt <= 1'b0;
        end else begin
            interrupt <= |(irq_en_r & irq_src_s);
        end
    end

    // STATUS byte assembly.
    always_comb begin
        status_s                = 8'h00;
        status_s[ST_TX_HALF]    = tx_half_s;
        status_s[ST_TX_FULL]    = tx_full_s;
        status_s[ST_RX_HALF]    = rx_half_s;
        status_s[ST_RX_FULL]    = rx_full_s;
        status_s[ST_RX_PRESENT] = !rx_empty_s;
        status_s[ST_FRAME_ERR]  = frame_err_r;
        status_s[ST_OVERRUN]    = overrun_r;
        status_s[ST_IRQ_PEND]   = interrupt;
    end

    // Read multiplexer, driven purely by the current port_id.
    always_comb begin
        rd_data_s = 8'h00;
        if (in_range_s) begin
            case (ofs_s[2:0])
                OFS_STATUS: rd_data_s = status_s;
                OFS_DATA:   rd_data_s = rx_empty_s ? 8'h00 : rx_head_s;
                OFS_DIV_LO: rd_data_s = div_r[7:0];
                OFS_DIV_HI: rd_data_s = div_r[15:8];
                OFS_IRQ_EN: rd_data_s = {5'd0, irq_en_r};
                default:    rd_data_s = 8'h00;
            endcase
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // One-cycle read latency to the processor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_port <= 8'h00;
        end else begin
            in_port <= rd_data_s;
        end
    end

endmodule

// File: tb/tb_pblaze_uart_port.sv
// Self-checking bench for pblaze_uart_port: random bytes through TX and RX,
// checked against queue-based expectations and a line-level frame decoder.
module tb_pblaze_uart_port;

    localparam logic [7:0] BASE  = 8'h20;
    localparam int         DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       rx;
    logic       tx;

    pblaze_uart_port #(.BASE_PORT(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd26)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .rx           (rx),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int bit_clks = 416;
    int tx_bad_stop = 0;
    logic [7:0] tx_seen[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int bit_time(input int div);
        return 16 * ((div == 0) ? 1 : div);
    endfunction

    // Line-level TX decoder: centre-samples each bit of every frame on tx.
    initial begin : tx_monitor
        logic [7:0] d;
        int b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                b = bit_clks;
                repeat (b / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (b) @(negedge clk);
                    d[i] = tx;
                end
                repeat (b) @(negedge clk);
                if (tx !== 1'b1) tx_bad_stop++;
                tx_seen.push_back(d);
            end
        end
    end

    task automatic io_write(input logic [7:0] ofs, input logic [7:0] d);
        @(negedge clk);
        port_id = BASE + ofs;
        out_port = d;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] ofs, output logic [7:0] d);
        @(negedge clk);
        port_id = BASE + ofs;
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        d = in_port;
    endtask

    task automatic set_div(input logic [15:0] d);
        io_write(8'd2, d[7:0]);
        io_write(8'd3, d[15:8]);
        bit_clks = bit_time(int'(d));
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx = stop;
        repeat (bit_clks) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && tx_seen.size() < n; i++) @(negedge clk);
        check_eq("tx_frame_count", tx_seen.size(), n);
    endtask

    initial begin : main
        logic [7:0] rd;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       ovr_model;
        int         cnt;
        int         divs[3];

        rst_n = 1'b0; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; rx = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_tx", tx, 1'b1);
        check_eq("reset_irq", interrupt, 1'b0);
        check_eq("reset_in_port", in_port, 8'h00);
        rst_n = 1'b1;
        io_read(8'd0, rd); check_eq("reset_status", rd, 8'h00);
        io_read(8'd2, rd); check_eq("reset_div_lo", rd, 8'd26);
        io_read(8'd3, rd); check_eq("reset_div_hi", rd, 8'h00);
        io_read(8'd4, rd); check_eq("reset_irq_en", rd, 8'h00);

        // Register map edges
        io_write(8'd4, 8'hFF);
        io_read(8'd4, rd); check_eq("irq_en_mask", rd, 8'h07);
        io_read(8'd5, rd); check_eq("unmapped_plus5", rd, 8'h00);
        io_read(8'hFF, rd); check_eq("unmapped_below", rd, 8'h00);
        io_write(8'd4, 8'h02);
        @(negedge clk);
        check_eq("irq_tx_idle", interrupt, 1'b1);
        io_write(8'd4, 8'h00);
        @(negedge clk);
        check_eq("irq_off", interrupt, 1'b0);

        // 0x55 at DIV=26
        io_write(8'd1, 8'h55);
        io_read(8'd0, rd); check_eq("tx_half_single", rd[0], 1'b0);
        cnt = 0;
        while (tx !== 1'b0 && cnt < 2000) begin @(negedge clk); cnt++; end
        check_eq("tx_start_seen", tx, 1'b0);
        cnt = 0;
        while (tx === 1'b0 && cnt < 2000) begin @(negedge clk); cnt++; end
        check_eq("tx_bit_clks", cnt, 416);
        wait_tx(1, 6000);
        if (tx_seen.size() > 0) check_eq("tx_0x55", tx_seen.pop_front(), 8'h55);

        // 0xA3 received at DIV=26
        drive_rx(8'hA3, 1'b1);
        io_read(8'd0, rd); check_eq("rx_present_set", rd[4], 1'b1);
        io_read(8'd1, rd); check_eq("rx_0xA3", rd, 8'hA3);
        io_read(8'd0, rd); check_eq("rx_present_clr", rd[4], 1'b0);

        // 200 ns glitch on idle rx
        @(negedge clk); rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (11 * bit_clks) @(negedge clk);
        io_read(8'd0, rd); check_eq("glitch_status", rd, 8'h00);

        // Framing error with IRQ_EN = 3'b100
        set_div(16'd2);
        io_write(8'd4, 8'h04);
        drive_rx(8'($urandom_range(0, 255)), 1'b0);
        repeat (2 * bit_clks) @(negedge clk);
        io_read(8'd0, rd);
        check_eq("frame_err_set", rd[5], 1'b1);
        check_eq("frame_no_push", rd[4], 1'b0);
        check_eq("frame_irq", interrupt, 1'b1);
        io_write(8'd0, 8'h20);
        @(negedge clk);
        check_eq("frame_irq_clr", interrupt, 1'b0);
        io_read(8'd0, rd); check_eq("frame_err_clr", rd, 8'h00);

        // RX overrun: DEPTH+1 unread frames
        exp_q.delete();
        ovr_model = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else ovr_model = 1'b1;
            drive_rx(b, 1'b1);
        end
        repeat (bit_clks) @(negedge clk);
        io_read(8'd0, rd);
        check_eq("ovr_status", rd, {1'b1, ovr_model, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00});
        for (int i = 0; i < DEPTH; i++) begin
            io_read(8'd1, rd);
            check_eq("ovr_data", rd, exp_q[i]);
        end
        io_read(8'd1, rd); check_eq("rx_empty_reads_0", rd, 8'h00);
        io_write(8'd0, 8'h40);
        io_read(8'd0, rd); check_eq("ovr_clear", rd, 8'h00);
        io_write(8'd4, 8'h00);

        // TX overflow with the baud clock parked
        set_div(16'hFFFF);
        exp_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            io_write(8'd1, b);
        end
        io_read(8'd0, rd); check_eq("tx_full_status", rd[1:0], 2'b11);
        set_div(16'd2);
        wait_tx(DEPTH, DEPTH * 10 * bit_clks + 2000);
        for (int i = 0; i < DEPTH && tx_seen.size() > 0; i++)
            check_eq("tx_burst_data", tx_seen.pop_front(), exp_q[i]);
        repeat (30 * bit_clks) @(negedge clk);
        check_eq("tx_drop_last", tx_seen.size(), 0);

        // Random traffic at several divisors including 0
        divs[0] = 0; divs[1] = 1; divs[2] = 3;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] txq[$];
            logic [7:0] rxq[$];
            set_div(16'(divs[k]));
            io_read(8'd2, rd); check_eq("div_lo_rb", rd, 8'(divs[k]));
            for (int i = 0; i < 5; i++) begin
                txq.push_back(8'($urandom_range(0, 255)));
                rxq.push_back(8'($urandom_range(0, 255)));
            end
            fork
                begin
                    for (int i = 0; i < 5; i++) io_write(8'd1, txq[i]);
                end
                begin
                    for (int i = 0; i < 5; i++) drive_rx(rxq[i], 1'b1);
                end
            join
            wait_tx(5, 60 * bit_clks + 1000);
            for (int i = 0; i < 5 && tx_seen.size() > 0; i++)
                check_eq("rand_tx", tx_seen.pop_front(), txq[i]);
            for (int i = 0; i < 5; i++) begin
                io_read(8'd1, rd);
                check_eq("rand_rx", rd, rxq[i]);
            end
            io_read(8'd0, rd); check_eq("rand_status", rd, 8'h00);
        end
        check_eq("tx_stop_bits", tx_bad_stop, 0);

        // Reset in the middle of a transmitted byte
        set_div(16'd2);
        io_write(8'd1, 8'h00);
        cnt = 0;
        while (tx !== 1'b0 && cnt < 500) begin @(negedge clk); cnt++; end
        repeat (3 * bit_clks) @(negedge clk);
        check_eq("mid_byte_low", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_tx", tx, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        io_read(8'd0, rd); check_eq("post_reset_status", rd, 8'h00);
        io_read(8'd2, rd); check_eq("post_reset_div", rd, 8'd26);
        repeat (12 * bit_clks) @(negedge clk);
        tx_seen.delete();
        bit_clks = bit_time(26);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
